// File: rtl/gray_pkg.sv
// Shared types and helpers for Gray-code receivers: FSM state encoding and
// width-generic Gray/binary conversion functions.
package gray_pkg;

    typedef enum logic [1:0] {
        ACQ,
        TRACK,
        RECOVER
    } gray_rx_state_e;

    localparam int GRAY_MAX_WIDTH = 32;

    // Narrower values are zero-extended; zero upper bits leave the prefix XOR unaffected.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin = '0;
        for (int i = 0; i < GRAY_MAX_WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary decoder: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray_to_bin #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] gray,
    output logic [DATA_WIDTH-1:0] bin
);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[DATA_WIDTH-1:i];
    end

endmodule

// File: rtl/gray_stream_decoder.sv
// Samples a Gray-coded count stream, decodes it to binary, checks each sample
// for legal forward single-step progress and tracks lock and error count.
module gray_stream_decoder
    import gray_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_gray,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_bin,
    output logic                  out_err,
    output logic                  out_dup,
    output logic                  locked,
    output logic [ERR_WIDTH-1:0]  err_count
);

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_gray;
    logic [DATA_WIDTH-1:0] dec_bin;
    logic [DATA_WIDTH-1:0] ref_gray;
    logic [DATA_WIDTH-1:0] ref_bin;

    gray_rx_state_e state;
    gray_rx_state_e state_next;

    logic is_dup;
    logic is_good;
    logic load_ref;
    logic err_flag;
    logic dup_flag;

    gray_to_bin #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_decode (
        .gray(s1_gray),
        .bin (dec_bin)
    );

    assign is_dup  = (s1_gray == ref_gray);
    assign is_good = (dec_bin == ref_bin + DATA_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ACQ;
            locked <= 1'b0;
        end else begin
            state  <= state_next;
            locked <= (state_next == TRACK);
        end
    end

    // A bad sample always resyncs the reference so recovery is judged from the latest value.
    always_comb begin
        state_next = state;
        load_ref   = 1'b0;
        err_flag   = 1'b0;
        dup_flag   = 1'b0;
        if (s1_valid) begin
            case (state)
                ACQ: begin
                    load_ref   = 1'b1;
                    state_next = TRACK;
                end
                TRACK: begin
                    if (is_good) begin
                        load_ref = 1'b1;
                    end else if (is_dup) begin
                        dup_flag = 1'b1;
                    end else begin
                        err_flag   = 1'b1;
                        load_ref   = 1'b1;
                        state_next = RECOVER;
                    end
                end
                RECOVER: begin
                    if (is_good) begin
                        load_ref   = 1'b1;
                        state_next = TRACK;
                    end else if (is_dup) begin
                        dup_flag = 1'b1;
                    end else begin
                        err_flag = 1'b1;
                        load_ref = 1'b1;
                    end
                end
                default: state_next = ACQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s1_gray   <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_err   <= 1'b0;
            out_dup   <= 1'b0;
            ref_gray  <= '0;
            ref_bin   <= '0;
            err_count <= '0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_gray <= in_gray;
            end
            if (s1_valid) begin
                out_bin <= dec_bin;
                out_err <= err_flag;
                out_dup <= dup_flag;
            end
            if (load_ref) begin
                ref_gray <= s1_gray;
                ref_bin  <= dec_bin;
            end
            if (err_flag && (err_count != {ERR_WIDTH{1'b1}})) begin
                err_count <= err_count + ERR_WIDTH'(1);
            end
        end
    end

endmodule
